ext_mod: RTL and testbench

//   Small external register file hung off a ghostbus passenger port.

---
 rtl/ext_mod.sv | 53 +++++
 tb/tb_ext_mod.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ext_mod.sv
// ext_mod: small external register file used as a leaf target.
// 2**aw words of dw bits. Writes happen on a single-cycle strobe, and reads are
// registered with one cycle of latency. A read that hits the word being written
// returns the old contents. Asynchronous reset loads word i with RST_BASE+i.
module ext_mod #(
   parameter int unsigned aw       = 2,
   parameter int unsigned dw       = 8,
   parameter logic [63:0] RST_BASE = 64'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [aw-1:0] addr,
   input  logic [dw-1:0] din,
   output logic [dw-1:0] dout,
   input  logic          we
);

   localparam int unsigned DEPTH = 1 << aw;

   logic [dw-1:0] mem_q [DEPTH];
   logic [dw-1:0] dout_q;
   logic [dw-1:0] dout_d;

   // Reset value of word idx: the sum is truncated to dw bits, so it wraps modulo 2**dw.
   function automatic logic [dw-1:0] rst_word(input int unsigned idx);
      logic [63:0] sum;
      sum = RST_BASE + 64'(idx);
      return sum[dw-1:0];
   endfunction

   // Read mux from current storage; sampling it at the edge gives read-before-write.
   always_comb begin
      dout_d = mem_q[addr];
   end

   // Storage and registered read port. The reset values win over a write in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i[aw-1:0]] <= rst_word(i);
         end
         dout_q <= '0;
      end else begin
         if (we) begin
            mem_q[addr] <= din;
         end
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_ext_mod.sv
// Testbench for ext_mod. Two instances share stimulus: one with RST_BASE=0, one with RST_BASE=FE.
// Expected read data comes from a reference memory and is queued when a cycle is driven.
// The queued value is popped and compared after the edge that produces it.
module tb_ext_mod;

   logic       clk;
   logic       rst;
   logic [1:0] addr;
   logic [7:0] din;
   logic       we;
   logic [7:0] dout0;
   logic [7:0] dout1;

   int n_tests;
   int n_fail;

   logic [7:0] m0 [4];
   logic [7:0] m1 [4];
   logic [7:0] sb0 [$];
   logic [7:0] sb1 [$];

   ext_mod #(.aw(2), .dw(8), .RST_BASE(64'h00)) u_dut0 (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout0), .we(we)
   );

   ext_mod #(.aw(2), .dw(8), .RST_BASE(64'hFE)) u_dut1 (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout1), .we(we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   // Load the reference memories with their reset contents and drop any pending expectations.
   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m0[i] = 8'(i);
         m1[i] = 8'(8'hFE + i);
      end
      sb0.delete();
      sb1.delete();
   endtask

   // Drive one cycle. The read returns the old contents, so the expectation is queued before the model write.
   task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d);
      we   = w;
      addr = a;
      din  = d;
      sb0.push_back(m0[a]);
      sb1.push_back(m1[a]);
      if (w) begin
         m0[a] = d;
         m1[a] = d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e0, e1;
      rst = 1'b1; we = 1'b0; addr = '0; din = '0;
      model_reset();
      @(posedge clk); #1;
      n_tests++;
      if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout0: got %h, expected 00", dout0); end
      n_tests++;
      if (dout1 !== 8'h00) begin n_fail++; $display("FAIL reset_dout1: got %h, expected 00", dout1); end
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 2'(a), 8'h00);
         e0 = sb0.pop_front();
         e1 = sb1.pop_front();
         n_tests++;
         if (dout0 !== e0 || dout0 !== 8'(a)) begin
            n_fail++; $display("FAIL reset_read0[%0d]: got %h, expected %h", a, dout0, 8'(a));
         end
         n_tests++;
         if (dout1 !== e1 || dout1 !== 8'(8'hFE + a)) begin
            n_fail++; $display("FAIL reset_wrap1[%0d]: got %h, expected %h", a, dout1, 8'(8'hFE + a));
         end
      end
   endtask

   task automatic test_write();
      logic [7:0] e0;
      step(1'b1, 2'd2, 8'hA5);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 2'(a), 8'h00);
         e0 = sb0.pop_front();
         void'(sb1.pop_front());
         n_tests++;
         if (dout0 !== e0 || dout0 !== ((a == 2) ? 8'hA5 : 8'(a))) begin
            n_fail++; $display("FAIL write_read[%0d]: got %h, expected %h", a, dout0, e0);
         end
      end
   endtask

   task automatic test_rdw();
      logic [7:0] e0;
      step(1'b0, 2'd1, 8'h00);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      step(1'b1, 2'd1, 8'h3C);
      e0 = sb0.pop_front(); void'(sb1.pop_front());
      n_tests++;
      if (dout0 !== e0 || dout0 !== 8'h01) begin
         n_fail++; $display("FAIL rdw_old: got %h, expected 01", dout0);
      end
      step(1'b0, 2'd1, 8'h00);
      e0 = sb0.pop_front(); void'(sb1.pop_front());
      n_tests++;
      if (dout0 !== e0 || dout0 !== 8'h3C) begin
         n_fail++; $display("FAIL rdw_new: got %h, expected 3C", dout0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e0, e1;
      for (int a = 0; a < 4; a++) begin
         step(1'b1, 2'(a), 8'(8'h10 * (a + 1)));
         void'(sb0.pop_front()); void'(sb1.pop_front());
      end
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 2'(a), 8'h00);
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         n_tests++;
         if (dout0 !== e0 || dout0 !== 8'(8'h10 * (a + 1)) || dout1 !== e1) begin
            n_fail++; $display("FAIL b2b_read[%0d]: got %h/%h, expected %h/%h", a, dout0, dout1, e0, e1);
         end
      end
      // A reset arriving mid-cycle together with a write clears dout at once, and the write is lost.
      we = 1'b1; addr = 2'd3; din = 8'h77;
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
         n_fail++; $display("FAIL async_rst: got %h/%h, expected 00/00", dout0, dout1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 2'(a), 8'h00);
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         n_tests++;
         if (dout0 !== e0 || dout0 !== 8'(a) || dout1 !== e1) begin
            n_fail++; $display("FAIL reread[%0d]: got %h/%h, expected %h/%h", a, dout0, dout1, e0, e1);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] e0, e1;
      int bad;
      bad = 0;
      for (int c = 0; c < 10000; c++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         n_tests++;
         if (dout0 !== e0 || dout1 !== e1) begin
            n_fail++;
            if (bad < 10) $display("FAIL random[%0d]: got %h/%h, expected %h/%h", c, dout0, dout1, e0, e1);
            bad++;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_write();
      test_rdw();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
